mem_req_sequencer: RTL and testbench

- Upstream command stage for the 4096 x 8 synchronous memory. Clients issue single-byte read/write requests over a valid/ready interface.
- Requests are buffered in a small FIFO, then serialised onto the memory's readEnable/writeEnable/rwAddr/writeData_in pins.
- readData_out is captured on the correct cycle and returned over a valid/ready response channel.
- Guarantees the two memory enables are never asserted together.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_req_fifo.sv | 53 +++++
 rtl/mem_req_sequencer.sv | 96 +++++++++
 tb/tb_mem_req_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, command type and sequencer states
package mem_pkg;

  localparam int DATA_SIZE  = 8;
  localparam int ADDR_WIDTH = 12;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_SIZE-1:0]  wdata;
  } mem_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_CAPTURE,
    RSP
  } seq_state_e;

endpackage

// File: rtl/mem_req_fifo.sv
// rtl/mem_req_fifo.sv - request FIFO of mem_cmd_t entries with full/empty/count
module mem_req_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  mem_cmd_t               push_data,
  input  logic                   pop,
  output mem_cmd_t               pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  mem_cmd_t      entries [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is refused even if a pop frees a slot that cycle.
  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = entries[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) entries[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_req_sequencer.sv
// rtl/mem_req_sequencer.sv - serialises queued byte read/write requests onto a 4096x8 synchronous memory
module mem_req_sequencer #(
  parameter int DATA_SIZE  = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_SIZE-1:0]  req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_SIZE-1:0]  rsp_rdata,
  output logic                  wr_done,
  output logic                  busy,
  output logic                  mem_readEnable,
  output logic                  mem_writeEnable,
  output logic [ADDR_WIDTH-1:0] mem_rwAddr,
  output logic [DATA_SIZE-1:0]  mem_writeData_in,
  input  logic [DATA_SIZE-1:0]  mem_readData_out
);

  import mem_pkg::*;

  seq_state_e                  state;
  seq_state_e                  next_state;
  mem_cmd_t                    fifo_in;
  mem_cmd_t                    fifo_out;
  mem_cmd_t                    cmd;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign req_ready = !reset && !fifo_full;
  assign fifo_in   = {req_write, req_addr, req_wdata};

  mem_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (req_valid && req_ready),
    .push_data (fifo_in),
    .pop       (pop),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = fifo_out.write ? WRITE : RD_ISSUE;
        end
      end
      WRITE:      next_state = IDLE;
      RD_ISSUE:   next_state = RD_CAPTURE;
      RD_CAPTURE: next_state = RSP;
      RSP:        if (rsp_ready) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Enables are also gated on the latched opcode so they can never coexist.
  assign mem_writeEnable  = (state == WRITE) && cmd.write;
  assign mem_readEnable   = ((state == RD_ISSUE) || (state == RD_CAPTURE)) && !cmd.write;
  assign mem_rwAddr       = cmd.addr;
  assign mem_writeData_in = cmd.wdata;
  assign rsp_valid        = (state == RSP);
  assign busy             = (fifo_count != '0) || (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd       <= '0;
      rsp_rdata <= '0;
      wr_done   <= 1'b0;
    end else begin
      if (pop) cmd <= fifo_out;
      wr_done <= (state == WRITE);
      if (state == RD_CAPTURE) rsp_rdata <= mem_readData_out;
    end
  end

endmodule

// File: tb/tb_mem_req_sequencer.sv
// tb/tb_mem_req_sequencer.sv - self-checking bench with memory model and in-order scoreboard
module tb_mem_req_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [11:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_rdata;
  logic        wr_done;
  logic        busy;
  logic        mem_readEnable;
  logic        mem_writeEnable;
  logic [11:0] mem_rwAddr;
  logic [7:0]  mem_writeData_in;
  logic [7:0]  mem_readData_out;

  always #5 clock = ~clock;

  mem_req_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .wr_done          (wr_done),
    .busy             (busy),
    .mem_readEnable   (mem_readEnable),
    .mem_writeEnable  (mem_writeEnable),
    .mem_rwAddr       (mem_rwAddr),
    .mem_writeData_in (mem_writeData_in),
    .mem_readData_out (mem_readData_out)
  );

  // Synchronous 4096x8 memory: read data registered, driven only while readEnable is high.
  logic [7:0] tb_mem [4096];
  logic [7:0] rd_reg;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) tb_mem[i] <= 'x;
      rd_reg <= 'x;
    end else begin
      if (mem_writeEnable) tb_mem[mem_rwAddr] <= mem_writeData_in;
      if (mem_readEnable)  rd_reg <= tb_mem[mem_rwAddr];
    end
  end
  assign mem_readData_out = mem_readEnable ? rd_reg : 8'bz;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event not expected or not seen", name);
  endtask

  typedef struct packed {
    logic        w;
    logic [11:0] a;
    logic [7:0]  d;
    logic [7:0]  exp;
  } op_t;

  op_t        ops_q [$];
  logic [7:0] rsp_q [$];
  logic [7:0] rsp_log [$];
  logic [7:0] model_mem [4096];
  int         n_push = 0;
  int         n_rsp = 0;
  int         re_run = 0;
  logic       we_prev = 1'b0;

  // Scoreboard: requests take effect in acceptance order; reads see all earlier writes.
  always @(negedge clock) begin
    if (reset) begin
      ops_q.delete();
      rsp_q.delete();
      re_run = 0;
      we_prev = 1'b0;
      for (int i = 0; i < 4096; i++) model_mem[i] = 'x;
    end else begin
      check("en_excl", 32'(mem_readEnable && mem_writeEnable), 0);
      check("wr_done", 32'(wr_done), 32'(we_prev));
      check("we_len", 32'(mem_writeEnable && we_prev), 0);
      if (mem_writeEnable) begin
        if (ops_q.size() == 0 || !ops_q[0].w) flag("we_unexpected");
        else begin
          check("we_addr", 32'(mem_rwAddr), 32'(ops_q[0].a));
          check("we_data", 32'(mem_writeData_in), 32'(ops_q[0].d));
          void'(ops_q.pop_front());
        end
      end
      if (mem_readEnable) begin
        if (re_run == 0) begin
          if (ops_q.size() == 0 || ops_q[0].w) flag("re_unexpected");
          else begin
            check("re_addr", 32'(mem_rwAddr), 32'(ops_q[0].a));
            rsp_q.push_back(ops_q[0].exp);
            void'(ops_q.pop_front());
          end
        end
        re_run++;
      end else if (re_run != 0) begin
        check("re_len", re_run, 2);
        re_run = 0;
      end
      we_prev = mem_writeEnable;
      if (rsp_valid) begin
        if (rsp_q.size() == 0) flag("rsp_unexpected");
        else begin
          check("rsp_data", 32'(rsp_rdata), 32'(rsp_q[0]));
          if (rsp_ready) begin
            rsp_log.push_back(rsp_rdata);
            void'(rsp_q.pop_front());
            n_rsp++;
          end
        end
      end
      if (req_valid && req_ready) begin
        ops_q.push_back('{w: req_write, a: req_addr, d: req_wdata,
                          exp: req_write ? 8'bx : model_mem[req_addr]});
        if (req_write) model_mem[req_addr] = req_wdata;
        n_push++;
      end
    end
  end

  task automatic send(input logic w, input logic [11:0] a, input logic [7:0] d, output int e);
    logic rdy;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    e = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      rdy = req_ready;
      @(posedge clock);
      #1;
      if (rdy) begin
        e = cyc;
        break;
      end
    end
    if (e < 0) flag("send_timeout");
  endtask

  task automatic wait_idle();
    int done = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if (!busy && !rsp_valid && ops_q.size() == 0 && rsp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (done == 0) flag("idle_timeout");
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e2, lat, b, bp;

    repeat (3) @(posedge clock);
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_outputs", 32'({rsp_valid, wr_done, mem_readEnable, mem_writeEnable}), 0);
    check("rst_addr_data", 32'({mem_rwAddr, mem_writeData_in, rsp_rdata}), 0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", 32'(req_ready), 1);
    check("post_rst_busy", 32'(busy), 0);
    @(posedge clock);
    #1;

    // Latency: write then read of the same location.
    send(1'b1, 12'h123, 8'hA5, e);
    req_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (wr_done) begin
        lat = cyc - e;
        break;
      end
    end
    check("wr_latency", lat, 2);
    wait_idle();
    send(1'b0, 12'h123, 8'h00, e);
    req_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (rsp_valid) begin
        lat = cyc - e;
        break;
      end
    end
    check("rd_latency", lat, 3);
    check("rd_data_a5", 32'(rsp_rdata), 32'h0A5);
    wait_idle();

    // Backpressure: six queued reads against a stalled response channel.
    for (int i = 0; i < 6; i++) send(1'b1, 12'(12'h200 + i), 8'(8'h50 + i), e);
    req_valid = 1'b0;
    wait_idle();
    rsp_ready = 1'b0;
    b  = rsp_log.size();
    bp = n_push;
    fork
      begin
        for (int i = 0; i < 6; i++) send(1'b0, 12'(12'h200 + i), 8'h00, e2);
        req_valid = 1'b0;
      end
      begin
        repeat (14) @(negedge clock);
        check("full_ready", 32'(req_ready), 0);
        check("full_accepted", n_push - bp, 5);
        check("hold_valid", 32'(rsp_valid), 1);
        check("hold_data", 32'(rsp_rdata), 32'h50);
        @(posedge clock);
        #1;
        rsp_ready = 1'b1;
      end
    join
    wait_idle();
    check("drain_count", rsp_log.size() - b, 6);
    for (int i = 0; i < 6; i++)
      if (b + i < rsp_log.size()) check("drain_order", 32'(rsp_log[b + i]), 32'(8'(8'h50 + i)));

    // Address extremes, with the FIFO pointers well past one wrap.
    b = rsp_log.size();
    send(1'b1, 12'h000, 8'h11, e);
    send(1'b1, 12'hFFF, 8'hEE, e);
    send(1'b0, 12'h000, 8'h00, e);
    send(1'b0, 12'hFFF, 8'h00, e);
    req_valid = 1'b0;
    wait_idle();
    check("extreme_count", rsp_log.size() - b, 2);
    if (rsp_log.size() >= b + 2) begin
      check("extreme_lo", 32'(rsp_log[b]), 32'h11);
      check("extreme_hi", 32'(rsp_log[b + 1]), 32'hEE);
    end

    // Read-after-write ordering on one address.
    b = rsp_log.size();
    send(1'b1, 12'h010, 8'h3C, e);
    send(1'b0, 12'h010, 8'h00, e);
    send(1'b1, 12'h010, 8'hC3, e);
    send(1'b0, 12'h010, 8'h00, e);
    req_valid = 1'b0;
    wait_idle();
    check("raw_count", rsp_log.size() - b, 2);
    if (rsp_log.size() >= b + 2) begin
      check("raw_first", 32'(rsp_log[b]), 32'h3C);
      check("raw_second", 32'(rsp_log[b + 1]), 32'hC3);
    end

    // Asynchronous reset while the read is in its capture cycle.
    send(1'b1, 12'h321, 8'h77, e);
    send(1'b0, 12'h321, 8'h00, e);
    req_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (mem_readEnable) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) flag("rd_issue_seen");
    @(posedge clock);
    #3;
    check("cap_readEnable", 32'(mem_readEnable), 1);
    reset = 1'b1;
    #1;
    check("arst_rsp", 32'({rsp_valid, rsp_rdata}), 0);
    check("arst_enables", 32'({wr_done, mem_readEnable, mem_writeEnable}), 0);
    check("arst_addr_data", 32'({mem_rwAddr, mem_writeData_in}), 0);
    check("arst_ready_busy", 32'({req_ready, busy}), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    b = n_rsp;
    repeat (10) @(negedge clock);
    check("arst_no_rsp", n_rsp - b, 0);
    check("arst_busy", 32'(busy), 0);
    @(posedge clock);
    #1;
    b = rsp_log.size();
    send(1'b1, 12'h321, 8'h99, e);
    send(1'b0, 12'h321, 8'h00, e);
    req_valid = 1'b0;
    wait_idle();
    check("after_rst_count", rsp_log.size() - b, 1);
    if (rsp_log.size() > b) check("after_rst_data", 32'(rsp_log[b]), 32'h99);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
